// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, flag bit positions and the
// output-register state type used by the arbiter.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags. C is the adder carry-out
// (no-borrow for SUB); C and V are zero for logic ops.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  alu_control,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    is_sub = (alu_control == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
    result = '0;
    flags  = '0;
    case (alu_control)
      ALU_ADD, ALU_SUB: begin
        result         = sum[31:0];
        flags[FLAG_C]  = sum[32];
        flags[FLAG_V]  = (a[31] == b_eff[31]) && (sum[31] != a[31]);
      end
      ALU_AND: result = a & b;
      default: result = a | b;
    endcase
    flags[FLAG_N] = result[31];
    flags[FLAG_Z] = (result == 32'd0);
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of `valid` searching upward from `ptr`,
// wrapping modulo N_REQ. Purely combinational.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!grant_any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration and a
// single-entry, ID-tagged response register with valid/ready backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [3:0]            rsp_flags
);

  out_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;

  logic              can_accept;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [1:0]        alu_op;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [3:0]        alu_flags;

  // Accept only when the register is empty or is being drained this cycle.
  assign can_accept = (state_q == OUT_EMPTY) || rsp_ready;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .valid     (req_valid & {N_REQ{can_accept}}),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        alu_op = req_op[2*i +: 2];
        alu_a  = req_a[32*i +: 32];
        alu_b  = req_b[32*i +: 32];
      end
    end
  end

  alu u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_op),
    .result      (alu_result),
    .flags       (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (grant_any) begin
      state_d      = OUT_FULL;
      rsp_id_d     = grant_idx;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
      ptr_d        = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OUT_EMPTY;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_valid  = (state_q == OUT_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a cycle-level reference model predicts grants and
// responses into a queue; an independent monitor checks each response.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N_REQ = 2;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [2*N_REQ-1:0]   req_op;
  logic [32*N_REQ-1:0]  req_a;
  logic [32*N_REQ-1:0]  req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_result;
  logic [3:0]           rsp_flags;

  alu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     result;
    logic [3:0]      flags;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  bit   m_full;
  int   m_ptr;
  bit   rst_seen = 1'b0;

  always @(negedge reset_n) rst_seen = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each op, using wide signed/unsigned arithmetic.
  function automatic rsp_t ref_alu(input int id, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    rsp_t        r;
    longint      ua, ub, sa, sb, wide;
    logic [31:0] res;
    bit          c, v;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        res  = a + b;
        c    = (ua + ub) > 64'sd4294967295;
        wide = sa + sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      2'b01: begin
        res  = a - b;
        c    = (ua >= ub);
        wide = sa - sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      2'b10: res = a & b;
      default: res = a | b;
    endcase
    r.id     = ID_W'(id);
    r.result = res;
    r.flags  = {res[31], res == 32'd0, c, v};
    return r;
  endfunction

  // One clock of stimulus; the model predicts the grant and the next state.
  task automatic step(input logic [N_REQ-1:0] v, input logic [2*N_REQ-1:0] op,
                      input logic [32*N_REQ-1:0] a, input logic [32*N_REQ-1:0] b,
                      input logic rr);
    logic [N_REQ-1:0] exp_ready;
    int               g;
    bit               can_acc;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    can_acc = !m_full || rr;
    g = -1;
    if (can_acc) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx = (m_ptr + k) % N_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      exp_q.push_back(ref_alu(g, op[2*g +: 2], a[32*g +: 32], b[32*g +: 32]));
      m_ptr  = (g + 1) % N_REQ;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic one(input int lane, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic rr);
    logic [N_REQ-1:0]    v  = '0;
    logic [2*N_REQ-1:0]  o  = '0;
    logic [32*N_REQ-1:0] av = '0;
    logic [32*N_REQ-1:0] bv = '0;
    v[lane]           = 1'b1;
    o[2*lane +: 2]    = op;
    av[32*lane +: 32] = a;
    bv[32*lane +: 32] = b;
    step(v, o, av, bv, rr);
  endtask

  task automatic idle(input logic rr);
    step('0, '0, '0, '0, rr);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_step(input logic [N_REQ-1:0] v, input logic rr);
    logic [2*N_REQ-1:0]  o;
    logic [32*N_REQ-1:0] av, bv;
    for (int i = 0; i < N_REQ; i++) begin
      o[2*i +: 2]    = 2'($urandom);
      av[32*i +: 32] = rnd_operand();
      bv[32*i +: 32] = rnd_operand();
    end
    step(v, o, av, bv, rr);
  endtask

  // Monitor: pops one expectation per response handshake; checks hold while stalled.
  initial begin
    rsp_t exp_r, prev;
    bit   hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_seen) begin
        hold     = 1'b0;
        rst_seen = 1'b0;
      end
      if (hold) begin
        check("hold_id",     64'(rsp_id),     64'(prev.id));
        check("hold_result", 64'(rsp_result), 64'(prev.result));
        check("hold_flags",  64'(rsp_flags),  64'(prev.flags));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          exp_r = exp_q.pop_front();
          check("rsp_id",     64'(rsp_id),     64'(exp_r.id));
          check("rsp_result", 64'(rsp_result), 64'(exp_r.result));
          check("rsp_flags",  64'(rsp_flags),  64'(exp_r.flags));
        end
      end
      hold = rsp_valid && !rsp_ready;
      prev = {rsp_id, rsp_result, rsp_flags};
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_full    = 1'b0;
    m_ptr     = 0;
    #12;
    check("reset_valid",  64'(rsp_valid),  64'(0));
    check("reset_id",     64'(rsp_id),     64'(0));
    check("reset_result", 64'(rsp_result), 64'(0));
    check("reset_flags",  64'(rsp_flags),  64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Signed overflow on ADD, then equal-operand SUB.
    one(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    idle(1'b1);
    one(1, ALU_SUB, 32'd5, 32'd5, 1'b1);
    idle(1'b1);

    // Both requesting continuously: alternating grants, one response per cycle.
    repeat (6) rnd_step('1, 1'b1);
    idle(1'b1);

    // Stall with req0 pending, then release.
    one(0, ALU_ADD, 32'd10, 32'd20, 1'b1);
    repeat (3) rnd_step(2'b01, 1'b0);
    one(0, ALU_SUB, 32'd3, 32'd7, 1'b1);
    idle(1'b1);

    // Logic ops: C and V must be zero.
    one(0, ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
    one(0, ALU_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
    idle(1'b1);

    // Asynchronous reset while FULL and stalled; pointer must return to 0.
    one(0, ALU_ADD, 32'd3, 32'd4, 1'b0);
    idle(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid",  64'(rsp_valid),  64'(0));
    check("async_rst_id",     64'(rsp_id),     64'(0));
    check("async_rst_result", 64'(rsp_result), 64'(0));
    check("async_rst_flags",  64'(rsp_flags),  64'(0));
    m_full = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rnd_step('1, 1'b1);
    rnd_step('1, 1'b1);
    idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      rnd_step(N_REQ'($urandom), ($urandom % 4) != 0);
    end

    repeat (4) idle(1'b1);
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_valid", 64'(rsp_valid),    64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between N_REQ requesters, e.g. the execute stage and a debug/self-test port.
- Round-robin arbitration picks one request per cycle and applies its operands to the ALU.
- Result and flags go into a single-entry output register with valid/ready backpressure.
- The response is tagged with the requester ID so each requester can recognise its own result.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of the requester ID tag; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_op  input  2*N_REQ  per-requester ALUControl: 00 ADD, 01 SUB, 10 AND, 11 OR.
- req_a  input  32*N_REQ  per-requester operand a.
- req_b  input  32*N_REQ  per-requester operand b.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_result  output  32  ALU result.
- rsp_flags  output  4  ALU flags {N,Z,C,V}.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0.
  - RR pointer = 0, so requester 0 has highest priority after reset.
  - Any in-flight result is discarded.
- Output register state machine:
  - EMPTY when rsp_valid=0; FULL when rsp_valid=1.
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration (combinational, same cycle):
  - If can_accept and any req_valid is set, grant the first valid requester searching from ptr upward, wrapping modulo N_REQ.
  - req_ready[g]=1 for the granted index only; all other bits are 0.
  - If can_accept=0, req_ready is all-zero.
  - req_ready must not depend on req_valid of the same index combinationally beyond the grant logic; there is no loop through rsp_ready back into the alu.
- Datapath:
  - The granted requester's op/a/b are muxed onto the alu inputs.
  - When no grant is made, the alu inputs are driven to 0 (op=00).
- Latency: on a grant edge, rsp_result/rsp_flags/rsp_id capture the alu outputs and rsp_valid=1. The response is visible the cycle after the handshake (1-cycle latency).
- State transitions:
  - EMPTY + grant -> FULL.
  - FULL + rsp_ready + grant -> FULL, register loaded with the new result (back-to-back throughput of 1 per cycle).
  - FULL + rsp_ready + no grant -> EMPTY.
  - FULL + !rsp_ready -> FULL, all rsp_* held stable.
- RR pointer:
  - On a grant to index g, ptr <= (g+1) mod N_REQ.
  - No grant leaves the pointer unchanged.
  - Result: a continuously-requesting requester waits at most N_REQ-1 grants.
- Flags are exactly those of `alu`:
  - N = result[31]; Z = (result==0).
  - C and V are valid for ADD/SUB only and forced to 0 for AND/OR.
- Requester-side rules:
  - Requester operands may change freely while req_ready=0.
  - A request is consumed only on req_valid & req_ready at the clock edge.
- Unused req lanes: if req_valid is X/0 for a lane, that lane is never granted.

Decomposition:
- Shared package `alu_pkg`:
  - ALU op enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
  - Flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module: instantiate the existing `alu` unchanged.
- The round-robin picker may be a small sub-module `rr_picker` (inputs: valid vector, ptr; output: one-hot grant plus index).

Test Plan:
- Req0 ADD a=0x7FFFFFFF b=0x00000001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0x80000000, rsp_flags=4'b1001.
- Req1 SUB a=5 b=5 -> rsp_result=0x00000000, rsp_flags=4'b0110, rsp_id=1.
- Both requesters valid continuously, rsp_ready=1, from reset -> grants alternate 0,1,0,1; one response per cycle with no bubbles.
- FULL with rsp_ready=0 for 3 cycles while req0 is valid -> req_ready=0; rsp_result/flags/id held. Raising rsp_ready -> the new req0 result appears the following cycle.
- Req0 AND a=0xF0F0F0F0 b=0x0F0F0F0F -> result 0, flags 4'b0100; then OR with the same operands -> 0xFFFFFFFF, flags 4'b1000.
- Assert reset_n=0 mid-cycle while FULL -> rsp_valid drops immediately (asynchronously); after release, ptr=0, so with both requesters valid req0 is granted first.
